// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host-transmit FSM states, command bytes and
// the microsecond-to-clock-cycle helper used to size timers.
package ps2_pkg;

    typedef enum logic [3:0] {
        IDLE,
        INHIBIT,
        REQ,
        DATA,
        PARITY,
        STOP,
        ACK,
        WAIT_IDLE,
        FAIL
    } ps2_state_e;

    localparam logic [7:0] PS2_CMD_RESET   = 8'hFF;
    localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
    localparam logic [7:0] PS2_CMD_ENABLE  = 8'hF4;
    localparam logic [7:0] PS2_ACK         = 8'hFA;

    // 64-bit product keeps large clock rates times long timeouts from overflowing.
    function automatic int unsigned us_to_cycles(input int unsigned clk_hz,
                                                 input int unsigned us);
        logic [63:0] prod;
        prod = 64'(clk_hz) * 64'(us);
        return 32'(prod / 64'd1000000);
    endfunction

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Byte-level request/response bundle between a command source and the
// PS/2 host transmitter.
interface ps2_host_tx_if;

    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_done;
    logic       tx_error;
    logic       busy;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready,
        input  tx_done,
        input  tx_error,
        input  busy
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready,
        output tx_done,
        output tx_error,
        output busy
    );

endinterface

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizer for one PS/2 line plus a falling-edge flag on the
// synchronized level; idles high to match the pulled-up bus.
module ps2_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic i_line,
    output logic o_sync,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
            r_prev <= 1'b1;
        end else begin
            r_meta <= i_line;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_sync = r_sync;
    assign o_fall = r_prev & ~r_sync;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter driving open-drain output enables.
// Optional macro PS2_HOST_TX_RETRY_EN: retry NACK/timeout up to MAX_RETRY times.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ      = 50000000,
    parameter int unsigned INHIBIT_US       = 120,
    parameter int unsigned START_TIMEOUT_US = 15000,
    parameter int unsigned FRAME_TIMEOUT_US = 2000,
    parameter int unsigned MAX_RETRY        = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ps2_clk_in,
    input  logic         ps2_data_in,
    output logic         ps2_clk_oe,
    output logic         ps2_data_oe,
    ps2_host_tx_if.slave tx_if
);

    localparam int unsigned INHIBIT_CYC = us_to_cycles(CLK_FREQ_HZ, INHIBIT_US);
    localparam int unsigned START_CYC   = us_to_cycles(CLK_FREQ_HZ, START_TIMEOUT_US);
    localparam int unsigned FRAME_CYC   = us_to_cycles(CLK_FREQ_HZ, FRAME_TIMEOUT_US);
    localparam int unsigned MAX_CYC     = max_u(INHIBIT_CYC, max_u(START_CYC, FRAME_CYC));
    localparam int unsigned CNT_W       = $clog2(MAX_CYC);

    // Counter counts down to zero, so each load is one less than the duration.
    localparam logic [CNT_W-1:0] INHIBIT_LD = CNT_W'(INHIBIT_CYC - 1);
    localparam logic [CNT_W-1:0] START_LD   = CNT_W'(START_CYC - 1);
    localparam logic [CNT_W-1:0] FRAME_LD   = CNT_W'(FRAME_CYC - 1);

    ps2_state_e       r_state;
    ps2_state_e       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [2:0]       r_bit;
    logic [2:0]       w_bit_nxt;
    logic             r_data_oe;
    logic             w_data_oe_nxt;
    logic [7:0]       r_shift;
    logic [7:0]       w_shift_nxt;
    logic             r_parity;
    logic             w_parity_nxt;

    logic             w_clk_sync;
    logic             w_clk_fall;
    logic             w_data_sync;
    logic             w_data_fall_unused;
    logic             w_expired;
    logic             w_timed;
    logic             w_fail;

`ifdef PS2_HOST_TX_RETRY_EN
    localparam int unsigned RTY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    logic [RTY_W-1:0] r_retry;
    logic [RTY_W-1:0] w_retry_nxt;
    logic [7:0]       r_byte;
`else
    logic             w_retry_unused;

    assign w_retry_unused = (MAX_RETRY != 0);
`endif

    ps2_sync_edge u_clk_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_line (ps2_clk_in),
        .o_sync (w_clk_sync),
        .o_fall (w_clk_fall)
    );

    ps2_sync_edge u_data_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_line (ps2_data_in),
        .o_sync (w_data_sync),
        .o_fall (w_data_fall_unused)
    );

    assign w_expired = (r_cnt == '0);
    assign w_timed   = r_state inside {REQ, DATA, PARITY, STOP, ACK, WAIT_IDLE};

    // Next-state and datapath; an edge always wins over a same-cycle expiry.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_bit_nxt     = r_bit;
        w_data_oe_nxt = r_data_oe;
        w_shift_nxt   = r_shift;
        w_parity_nxt  = r_parity;
        w_fail        = 1'b0;
`ifdef PS2_HOST_TX_RETRY_EN
        w_retry_nxt   = r_retry;
`endif
        if (w_timed) begin
            w_cnt_nxt = r_cnt - CNT_W'(1);
        end

        case (r_state)
            IDLE: begin
                w_data_oe_nxt = 1'b0;
                if (tx_if.tx_valid) begin
                    w_shift_nxt  = tx_if.tx_data;
                    w_parity_nxt = ~^tx_if.tx_data;
                    w_cnt_nxt    = INHIBIT_LD;
                    w_state_nxt  = INHIBIT;
`ifdef PS2_HOST_TX_RETRY_EN
                    w_retry_nxt  = '0;
`endif
                end
            end
            INHIBIT: begin
                if (w_expired) begin
                    w_data_oe_nxt = 1'b1;
                    w_cnt_nxt     = START_LD;
                    w_state_nxt   = REQ;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            REQ: begin
                if (w_clk_fall) begin
                    w_data_oe_nxt = ~r_shift[0];
                    w_shift_nxt   = {1'b0, r_shift[7:1]};
                    w_bit_nxt     = 3'd1;
                    w_cnt_nxt     = FRAME_LD;
                    w_state_nxt   = DATA;
                end else if (w_expired) begin
                    w_fail = 1'b1;
                end
            end
            DATA: begin
                if (w_clk_fall) begin
                    w_data_oe_nxt = ~r_shift[0];
                    w_shift_nxt   = {1'b0, r_shift[7:1]};
                    w_bit_nxt     = r_bit + 3'd1;
                    if (r_bit == 3'd7) begin
                        w_state_nxt = PARITY;
                    end
                end else if (w_expired) begin
                    w_fail = 1'b1;
                end
            end
            PARITY: begin
                if (w_clk_fall) begin
                    w_data_oe_nxt = ~r_parity;
                    w_state_nxt   = STOP;
                end else if (w_expired) begin
                    w_fail = 1'b1;
                end
            end
            STOP: begin
                if (w_clk_fall) begin
                    w_data_oe_nxt = 1'b0;
                    w_state_nxt   = ACK;
                end else if (w_expired) begin
                    w_fail = 1'b1;
                end
            end
            ACK: begin
                if (w_clk_fall) begin
                    if (w_data_sync) begin
                        w_fail = 1'b1;
                    end else begin
                        w_state_nxt = WAIT_IDLE;
                    end
                end else if (w_expired) begin
                    w_fail = 1'b1;
                end
            end
            WAIT_IDLE: begin
                if (w_clk_sync && w_data_sync) begin
                    w_state_nxt = IDLE;
                end else if (w_expired) begin
                    w_fail = 1'b1;
                end
            end
            FAIL: begin
                w_data_oe_nxt = 1'b0;
                w_state_nxt   = IDLE;
            end
            default: begin
                w_data_oe_nxt = 1'b0;
                w_state_nxt   = IDLE;
            end
        endcase

        if (w_fail) begin
            w_data_oe_nxt = 1'b0;
`ifdef PS2_HOST_TX_RETRY_EN
            if (32'(r_retry) < MAX_RETRY) begin
                w_retry_nxt = r_retry + RTY_W'(1);
                w_shift_nxt = r_byte;
                w_cnt_nxt   = INHIBIT_LD;
                w_state_nxt = INHIBIT;
            end else begin
                w_state_nxt = FAIL;
            end
`else
            w_state_nxt = FAIL;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_bit     <= '0;
            r_data_oe <= 1'b0;
`ifdef PS2_HOST_TX_RETRY_EN
            r_retry   <= '0;
`endif
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_bit     <= w_bit_nxt;
            r_data_oe <= w_data_oe_nxt;
`ifdef PS2_HOST_TX_RETRY_EN
            r_retry   <= w_retry_nxt;
`endif
        end
    end

    always_ff @(posedge clk) begin
        r_shift  <= w_shift_nxt;
        r_parity <= w_parity_nxt;
`ifdef PS2_HOST_TX_RETRY_EN
        if (r_state == IDLE && tx_if.tx_valid) begin
            r_byte <= tx_if.tx_data;
        end
`endif
    end

    // Start bit goes low during the final inhibit cycle, before clock release.
    assign ps2_clk_oe     = (r_state == INHIBIT);
    assign ps2_data_oe    = r_data_oe | ((r_state == INHIBIT) && w_expired);
    assign tx_if.tx_ready = (r_state == IDLE);
    assign tx_if.busy     = (r_state != IDLE);
    assign tx_if.tx_done  = (r_state == WAIT_IDLE) && w_clk_sync && w_data_sync;
    assign tx_if.tx_error = (r_state == FAIL);

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter. It sends one command byte (for example 0xED set-LEDs or 0xF4 enable) from the FPGA to a keyboard or mouse.
- It is the transmit counterpart of the existing PS/2 receive path and shares the same ps2_clk/ps2_data open-drain lines.
- The top level converts the output-enables to tri-state: line = oe ? 1'b0 : 1'bz.
- busy tells the receive path to ignore line activity during a transmission.

Parameters:
- CLK_FREQ_HZ, 50000000, system clock frequency.
- INHIBIT_US, 120, time ps2_clk is held low to request to send (must be ≥100).
- START_TIMEOUT_US, 15000, maximum wait from clock release to the device's first falling edge.
- FRAME_TIMEOUT_US, 2000, maximum time from the first falling edge to the ACK.
- MAX_RETRY, 2, retries after NACK or timeout (used only with the optional feature).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- ps2_clk_in  in  1  raw ps2_clk line level
- ps2_data_in  in  1  raw ps2_data line level
- ps2_clk_oe  out  1  1 = drive ps2_clk low
- ps2_data_oe  out  1  1 = drive ps2_data low
- tx_data  in  8  byte to send
- tx_valid  in  1  send request
- tx_ready  out  1  idle, request is accepted
- tx_done  out  1  1-cycle pulse: device ACKed
- tx_error  out  1  1-cycle pulse: NACK or timeout
- busy  out  1  transmission in progress

Behaviour:
- Reset (asynchronous, rst_n=0): state IDLE; outputs ps2_clk_oe=0, ps2_data_oe=0, tx_ready=1, tx_done=0, tx_error=0, busy=0.
  - The lines are released immediately, including during a frame.
- Input conditioning: ps2_clk_in and ps2_data_in pass through 2-flop synchronizers (reset value 1). A falling edge is flagged when the synchronized clock goes 1→0 between consecutive cycles.
- Handshake: the byte is accepted when tx_valid && tx_ready. tx_data is latched and odd parity (~^tx_data) is computed. tx_ready drops the next cycle. tx_valid while busy is ignored.
- State IDLE: ps2_clk_oe=0, ps2_data_oe=0, busy=0.
- State INHIBIT: ps2_clk_oe=1 for exactly INHIBIT_US×CLK_FREQ_HZ/1e6 cycles (6000 at default). On the last cycle, set ps2_data_oe=1 (start bit). Next state REQ.
- State REQ: ps2_clk_oe=0 and ps2_data_oe stays 1. The timeout counter is loaded with START_TIMEOUT. The first falling edge goes to DATA, bit index 0.
- State DATA: on falling edges 1..8, ps2_data_oe = ~shift[0], then shift right. The timeout counter is loaded with FRAME_TIMEOUT on the first edge.
- State PARITY: on falling edge 9, ps2_data_oe = ~parity.
- State STOP: on falling edge 10, ps2_data_oe=0 (release).
- State ACK: on falling edge 11, sample synchronized data. 0 = ACK, go to WAIT_IDLE; 1 = NACK, go to FAIL.
- State WAIT_IDLE: wait until both synchronized lines are 1, then pulse tx_done and return to IDLE.
  - Bounded by the frame timeout; expiry goes to FAIL.
- State FAIL: release both lines, pulse tx_error, return to IDLE.
- Timeout: counter expiry in REQ, DATA, PARITY, STOP, ACK or WAIT_IDLE goes to FAIL.
- Counter widths: $clog2 of the largest cycle count, computed from the parameters.
- Simultaneous events: timeout expiry and a falling edge in the same cycle resolve to the edge.
- Glitch filtering is out of scope for this block.
- tx_done and tx_error are mutually exclusive and occur at most once per accepted byte.

Optional Feature:
- Macro: PS2_HOST_TX_RETRY_EN.
- Defined: NACK or timeout re-enters INHIBIT with the latched byte, up to MAX_RETRY times. tx_error pulses only after the final failure, and busy stays high throughout.
- Undefined: the first failure goes straight to FAIL; MAX_RETRY is unused and no retry counter is synthesized.

Decomposition:
- Package ps2_pkg holds:
  - the state enum (IDLE, INHIBIT, REQ, DATA, PARITY, STOP, ACK, WAIT_IDLE, FAIL);
  - the command constants PS2_CMD_RESET=8'hFF, PS2_CMD_SET_LED=8'hED, PS2_CMD_ENABLE=8'hF4, PS2_ACK=8'hFA;
  - a us-to-cycles constant function.
- Sub-module ps2_sync_edge: 2-flop synchronizer plus falling-edge detector for one line. It is instantiated twice (clock and data) and is reusable by the receive path.

Test Plan:
- Send 0xF4 with a device model that clocks at 12.5 kHz and ACKs:
  - ps2_clk_oe is high for 6000 cycles;
  - the bits seen at the rising edges are 0,0,0,1,0,1,1,1,1, then parity 0, then stop 1;
  - tx_done pulses once and tx_error stays 0.
- Send 0xED, then 0xFF: parity bit 1 for both; data bits LSB first match.
- Model drives data=1 at the 11th edge (NACK): tx_error pulses, both oe are 0 afterwards, tx_ready returns to 1.
- Model never clocks: tx_error occurs exactly 750000 cycles after clock release; with PS2_HOST_TX_RETRY_EN, it occurs after 3 attempts.
- Assert rst_n=0 after edge 5: both oe go 0 in the same cycle with no tx_done pulse; a new 0xF4 after reset succeeds.
- tx_valid held high during a frame with tx_data changing to 0x00: the transmitted byte is unchanged and exactly one tx_done occurs per accepted request.
